axi_burst_mem_slave: RTL and testbench



---
 rtl/axi_burst_mem_pkg.sv | 38 +++
 rtl/axi_burst_mem_slave_addr_gen.sv | 30 +++
 rtl/axi_burst_mem_slave.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_mem_pkg.sv
// Shared types for axi_burst_mem_slave; WRAP support is enabled by defining AXI_BURST_MEM_SLV_WRAP_EN.
package axi_burst_mem_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } axi_resp_e;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } axi_burst_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

`ifdef AXI_BURST_MEM_SLV_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_burst_mem_slave_addr_gen.sv
// Next word index for a burst beat; WRAP stepping only exists when AXI_BURST_MEM_SLV_WRAP_EN is defined.
module axi_mem_addr_gen
   import axi_burst_mem_pkg::*;
#(
   parameter int IDX_W = 10
) (
   input  logic [IDX_W-1:0] idx_i,
   input  logic [7:0]       len_i,
   input  logic [1:0]       burst_i,
   output logic [IDX_W-1:0] idx_o
);

   logic [IDX_W-1:0] incr;
   logic [IDX_W-1:0] mask;
   logic [IDX_W-1:0] wrap;

   // Legal WRAP lengths are 2^n-1, so len doubles as the in-window offset mask.
   always_comb begin
      incr  = idx_i + IDX_W'(1);
      mask  = IDX_W'(len_i);
      wrap  = (idx_i & ~mask) | (incr & mask);
      idx_o = idx_i;
      if (burst_i == INCR) begin
         idx_o = incr;
      end else if (WRAP_EN && (burst_i == WRAP)) begin
         idx_o = wrap;
      end
   end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave with independent read and write FSMs, one burst outstanding each.
// WRAP bursts are accepted only when AXI_BURST_MEM_SLV_WRAP_EN is defined.
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | accepting W beats until wlast
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | presenting R beats until the rlast handshake
module axi_burst_mem_slave
   import axi_burst_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4,
   parameter int DEPTH  = 1024
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [ID_W-1:0]     s_awid,
   input  logic [ADDR_W-1:0]   s_awaddr,
   input  logic [7:0]          s_awlen,
   input  logic [2:0]          s_awsize,
   input  logic [1:0]          s_awburst,
   input  logic                s_awvalid,
   output logic                s_awready,
   input  logic [DATA_W-1:0]   s_wdata,
   input  logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_wlast,
   input  logic                s_wvalid,
   output logic                s_wready,
   output logic [ID_W-1:0]     s_bid,
   output logic [1:0]          s_bresp,
   output logic                s_bvalid,
   input  logic                s_bready,
   input  logic [ID_W-1:0]     s_arid,
   input  logic [ADDR_W-1:0]   s_araddr,
   input  logic [7:0]          s_arlen,
   input  logic [2:0]          s_arsize,
   input  logic [1:0]          s_arburst,
   input  logic                s_arvalid,
   output logic                s_arready,
   output logic [ID_W-1:0]     s_rid,
   output logic [DATA_W-1:0]   s_rdata,
   output logic [1:0]          s_rresp,
   output logic                s_rlast,
   output logic                s_rvalid,
   input  logic                s_rready
);

   localparam int STRB_W = DATA_W / 8;
   localparam int BYTE_W = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);

   function automatic axi_resp_e classify(input logic [ADDR_W-1:0] addr, input logic [2:0] size,
                                          input logic [1:0] burst, input logic [7:0] len);
      logic burst_ok;
      burst_ok = (burst == FIXED) || (burst == INCR) ||
                 (WRAP_EN && (burst == WRAP) && wrap_len_ok(len));
      if ((addr >> (IDX_W + BYTE_W)) != '0) return DECERR;
      if ((size != 3'(BYTE_W)) || !burst_ok) return SLVERR;
      return OKAY;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   w_state_e         w_state_q, w_state_d;
   logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [ID_W-1:0]  bid_q, bid_d;
   logic [1:0]       bresp_q, bresp_d;
   logic [IDX_W-1:0] w_idx_q, w_idx_d, w_idx_nxt;
   logic [7:0]       w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic [1:0]       w_burst_q, w_burst_d;
   axi_resp_e        w_err_q, w_err_d;
   logic             w_over_q, w_over_d, mem_we;

   r_state_e         r_state_q, r_state_d;
   logic             arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [ID_W-1:0]  rid_q, rid_d;
   logic [1:0]       rresp_q, rresp_d;
   logic [DATA_W-1:0] rdata_q;
   logic [IDX_W-1:0] r_idx_q, r_idx_d, r_idx_nxt, rg_idx, rd_idx;
   logic [7:0]       r_len_q, r_len_d, r_cnt_q, r_cnt_d, rg_len;
   logic [1:0]       r_burst_q, r_burst_d, rg_burst;
   logic             rd_load, rd_zero;
   axi_resp_e        ar_resp;

   assign ar_resp  = classify(s_araddr, s_arsize, s_arburst, s_arlen);
   assign rg_idx   = (r_state_q == R_IDLE) ? s_araddr[IDX_W+BYTE_W-1:BYTE_W] : r_idx_q;
   assign rg_len   = (r_state_q == R_IDLE) ? s_arlen : r_len_q;
   assign rg_burst = (r_state_q == R_IDLE) ? s_arburst : r_burst_q;

   axi_mem_addr_gen #(.IDX_W(IDX_W)) u_w_gen (
      .idx_i(w_idx_q), .len_i(w_len_q), .burst_i(w_burst_q), .idx_o(w_idx_nxt)
   );

   axi_mem_addr_gen #(.IDX_W(IDX_W)) u_r_gen (
      .idx_i(rg_idx), .len_i(rg_len), .burst_i(rg_burst), .idx_o(r_idx_nxt)
   );

   always_comb begin
      w_state_d = w_state_q;
      bvalid_d  = bvalid_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_burst_d = w_burst_q;
      w_err_d   = w_err_q;
      w_over_d  = w_over_q;
      mem_we    = 1'b0;
      unique case (w_state_q)
         W_IDLE: if (s_awvalid && awready_q) begin
            w_state_d = W_DATA;
            bid_d     = s_awid;
            w_idx_d   = s_awaddr[IDX_W+BYTE_W-1:BYTE_W];
            w_len_d   = s_awlen;
            w_burst_d = s_awburst;
            w_err_d   = classify(s_awaddr, s_awsize, s_awburst, s_awlen);
            w_cnt_d   = 8'd0;
            w_over_d  = 1'b0;
         end
         W_DATA: if (s_wvalid && wready_q) begin
            // Beats past AxLEN are accepted but never reach the array.
            mem_we  = (w_err_q == OKAY) && !w_over_q;
            w_idx_d = w_idx_nxt;
            w_cnt_d = w_cnt_q + 8'd1;
            if (w_cnt_q == w_len_q) w_over_d = 1'b1;
            if (s_wlast) begin
               w_state_d = W_RESP;
               bvalid_d  = 1'b1;
               if (w_err_q != OKAY)                      bresp_d = w_err_q;
               else if (w_over_q || (w_cnt_q != w_len_q)) bresp_d = SLVERR;
               else                                       bresp_d = OKAY;
            end
         end
         W_RESP: if (s_bready) begin
            w_state_d = W_IDLE;
            bvalid_d  = 1'b0;
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
   end

   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rid_d     = rid_q;
      rresp_d   = rresp_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_burst_d = r_burst_q;
      rd_load   = 1'b0;
      rd_idx    = r_idx_q;
      rd_zero   = (rresp_q != OKAY);
      unique case (r_state_q)
         R_IDLE: if (s_arvalid && arready_q) begin
            r_state_d = R_DATA;
            rvalid_d  = 1'b1;
            rlast_d   = (s_arlen == 8'd0);
            rid_d     = s_arid;
            rresp_d   = ar_resp;
            r_len_d   = s_arlen;
            r_burst_d = s_arburst;
            r_cnt_d   = 8'd0;
            rd_load   = 1'b1;
            rd_idx    = s_araddr[IDX_W+BYTE_W-1:BYTE_W];
            rd_zero   = (ar_resp != OKAY);
            r_idx_d   = r_idx_nxt;
         end
         R_DATA: if (s_rready) begin
            if (rlast_q) begin
               r_state_d = R_IDLE;
               rvalid_d  = 1'b0;
               rlast_d   = 1'b0;
            end else begin
               rd_load = 1'b1;
               r_cnt_d = r_cnt_q + 8'd1;
               rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
               r_idx_d = r_idx_nxt;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
   end

   // Storage has no reset so it survives an aresetn pulse.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_wstrb[b]) mem_q[w_idx_q][b*8 +: 8] <= s_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= '0;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_burst_q <= '0;
         w_err_q   <= OKAY;
         w_over_q  <= 1'b0;
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rresp_q   <= '0;
         rdata_q   <= '0;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_burst_q <= '0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_burst_q <= w_burst_d;
         w_err_q   <= w_err_d;
         w_over_q  <= w_over_d;
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         rresp_q   <= rresp_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_burst_q <= r_burst_d;
         if (rd_load) rdata_q <= rd_zero ? '0 : mem_q[rd_idx];
      end
   end

   assign s_awready = awready_q;
   assign s_wready  = wready_q;
   assign s_bvalid  = bvalid_q;
   assign s_bid     = bid_q;
   assign s_bresp   = bresp_q;
   assign s_arready = arready_q;
   assign s_rvalid  = rvalid_q;
   assign s_rlast   = rlast_q;
   assign s_rid     = rid_q;
   assign s_rresp   = rresp_q;
   assign s_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for axi_burst_mem_slave: drivers push expected B/R responses, a monitor pops and compares.
module tb_axi_burst_mem_slave;
   import axi_burst_mem_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;
   localparam int DEPTH  = 1024;
`ifdef AXI_BURST_MEM_SLV_WRAP_EN
   localparam bit TB_WRAP = 1'b1;
`else
   localparam bit TB_WRAP = 1'b0;
`endif

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic [ID_W-1:0] s_awid = '0, s_arid = '0, s_bid, s_rid;
   logic [ADDR_W-1:0] s_awaddr = '0, s_araddr = '0;
   logic [7:0] s_awlen = '0, s_arlen = '0;
   logic [2:0] s_awsize = '0, s_arsize = '0;
   logic [1:0] s_awburst = '0, s_arburst = '0, s_bresp, s_rresp;
   logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_wlast = 1'b0, s_arvalid = 1'b0;
   logic s_bready = 1'b0, s_rready = 1'b0;
   logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
   logic [DATA_W-1:0] s_wdata = '0, s_rdata;
   logic [DATA_W/8-1:0] s_wstrb = '0;

   always #5 aclk = ~aclk;

   axi_burst_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;
   typedef struct { logic [ID_W-1:0] id; logic [DATA_W-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

   int checks = 0;
   int errors = 0;
   b_exp_t b_q[$];
   r_exp_t r_q[$];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] wd[$];
   logic [DATA_W/8-1:0] ws[$];
   int rdy_mode = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void timeout(string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [1:0] burst, input logic [7:0] len);
      bit ok_burst;
      if (addr >= 32'(DEPTH * 4)) return DECERR;
      ok_burst = (burst == 2'd0) || (burst == 2'd1) ||
                 ((burst == 2'd2) && TB_WRAP && (len inside {8'd1, 8'd3, 8'd7, 8'd15}));
      if ((size != 3'd2) || !ok_burst) return SLVERR;
      return OKAY;
   endfunction

   function automatic int beat_idx(input logic [31:0] addr, input logic [1:0] burst,
                                   input logic [7:0] len, input int k);
      int start, n, base;
      start = int'(addr / 4) % DEPTH;
      n = int'(len) + 1;
      case (burst)
         2'd0: return start;
         2'd2: begin
            base = start - (start % n);
            return base + ((start % n) + k) % n;
         end
         default: return (start + k) % DEPTH;
      endcase
   endfunction

   initial forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
         0: begin s_rready = 1'b1; s_bready = 1'b1; end
         1: begin s_rready = ~s_rready; s_bready = 1'b1; end
         default: begin
            s_rready = 1'($urandom_range(0, 1));
            s_bready = 1'($urandom_range(0, 1));
         end
      endcase
   end

   logic held = 1'b0;
   logic [63:0] held_val;
   always @(negedge aclk) begin
      b_exp_t be;
      r_exp_t re;
      if (!aresetn) begin
         held = 1'b0;
      end else begin
         if (s_bvalid && s_bready) begin
            if (b_q.size() == 0) begin
               timeout("b_unexpected");
            end else begin
               be = b_q.pop_front();
               check("bid", 64'(s_bid), 64'(be.id));
               check("bresp", 64'(s_bresp), 64'(be.resp));
            end
         end
         if (s_rvalid) begin
            if (held) check("r_stall_hold", {25'd0, s_rid, s_rresp, s_rlast, s_rdata}, held_val);
            if (s_rready) begin
               held = 1'b0;
               if (r_q.size() == 0) begin
                  timeout("r_unexpected");
               end else begin
                  re = r_q.pop_front();
                  check("rid", 64'(s_rid), 64'(re.id));
                  check("rdata", 64'(s_rdata), 64'(re.data));
                  check("rresp", 64'(s_rresp), 64'(re.resp));
                  check("rlast", 64'(s_rlast), 64'(re.last));
               end
            end else begin
               held = 1'b1;
               held_val = {25'd0, s_rid, s_rresp, s_rlast, s_rdata};
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
      logic [1:0] resp;
      int n, t, idx;
      n = wd.size();
      resp = exp_resp(addr, size, burst, len);
      if (resp == OKAY) begin
         for (int k = 0; k < n && k <= int'(len); k++) begin
            idx = beat_idx(addr, burst, len, k);
            for (int b = 0; b < 4; b++)
               if (ws[k][b]) ref_mem[idx][b*8 +: 8] = wd[k][b*8 +: 8];
         end
      end else if (n != int'(len) + 1) begin
         resp = resp;
      end
      if (resp == OKAY && n != int'(len) + 1) resp = SLVERR;
      b_q.push_back('{id: id, resp: resp});
      @(negedge aclk);
      s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
      s_awvalid = 1'b1;
      t = 0;
      while (!s_awready && t < 200) begin @(negedge aclk); t++; end
      if (!s_awready) timeout("aw_handshake");
      @(negedge aclk);
      s_awvalid = 1'b0;
      for (int k = 0; k < n; k++) begin
         s_wvalid = 1'b1; s_wdata = wd[k]; s_wstrb = ws[k]; s_wlast = (k == n - 1);
         t = 0;
         while (!s_wready && t < 200) begin @(negedge aclk); t++; end
         if (!s_wready) timeout("w_handshake");
         if (k == n - 1) check("bvalid_before_wlast", 64'(s_bvalid), 64'd0);
         @(negedge aclk);
      end
      s_wvalid = 1'b0; s_wlast = 1'b0;
      check("bvalid_after_wlast", 64'(s_bvalid), 64'd1);
      wd.delete();
      ws.delete();
      t = 0;
      while (b_q.size() != 0 && t < 200) begin @(negedge aclk); t++; end
      if (b_q.size() != 0) begin timeout("b_response"); b_q.delete(); end
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit wait_done);
      logic [1:0] resp;
      int t;
      resp = exp_resp(addr, size, burst, len);
      for (int k = 0; k <= int'(len); k++)
         r_q.push_back('{id: id, data: (resp == OKAY) ? ref_mem[beat_idx(addr, burst, len, k)] : '0,
                         resp: resp, last: (k == int'(len))});
      @(negedge aclk);
      s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
      s_arvalid = 1'b1;
      t = 0;
      while (!s_arready && t < 200) begin @(negedge aclk); t++; end
      if (!s_arready) timeout("ar_handshake");
      @(negedge aclk);
      s_arvalid = 1'b0;
      check("rvalid_after_ar", 64'(s_rvalid), 64'd1);
      if (wait_done) begin
         t = 0;
         while (r_q.size() != 0 && t < 1000) begin @(negedge aclk); t++; end
         if (r_q.size() != 0) begin timeout("r_burst"); r_q.delete(); end
      end
   endtask

   initial begin
      repeat (3) @(negedge aclk);
      check("rst_readys", {61'd0, s_awready, s_wready, s_arready}, 64'd0);
      check("rst_valids", {61'd0, s_bvalid, s_rvalid, s_rlast}, 64'd0);
      check("rst_b", {58'd0, s_bid, s_bresp}, 64'd0);
      check("rst_r", {26'd0, s_rid, s_rresp, s_rdata}, 64'd0);
      aresetn = 1'b1;

      for (int k = 0; k < 256; k++) begin wd.push_back($urandom); ws.push_back(4'hF); end
      do_write(4'h1, 32'h0, 8'd255, 3'd2, 2'd1);

      for (int k = 0; k < 4; k++) begin wd.push_back(32'hA0 + k); ws.push_back(4'hF); end
      do_write(4'h3, 32'h100, 8'd3, 3'd2, 2'd1);
      do_read(4'h4, 32'h100, 8'd3, 3'd2, 2'd1, 1'b1);

      wd.push_back(32'hFFFF_FFFF); ws.push_back(4'h1);
      do_write(4'h5, 32'h100, 8'd0, 3'd2, 2'd1);
      do_read(4'h6, 32'h100, 8'd0, 3'd2, 2'd1, 1'b1);
      check("strobe_model", 64'(ref_mem[32'h40]), 64'h0000_00FF);

      do_read(4'h7, 32'(DEPTH * 4), 8'd1, 3'd2, 2'd1, 1'b1);

      rdy_mode = 1;
      do_read(4'h8, 32'h100, 8'd3, 3'd2, 2'd1, 1'b1);
      rdy_mode = 0;

      for (int k = 0; k < 2; k++) begin wd.push_back(32'hB0 + k); ws.push_back(4'hF); end
      do_write(4'h9, 32'h100, 8'd3, 3'd2, 2'd1);

      for (int k = 0; k < 4; k++) begin wd.push_back(32'hC0 + k); ws.push_back(4'hF); end
      do_write(4'hA, 32'h108, 8'd3, 3'd2, 2'd2);
      do_read(4'hB, 32'h100, 8'd3, 3'd2, 2'd1, 1'b1);

      for (int k = 0; k < 4; k++) begin wd.push_back(32'hD0 + k); ws.push_back(4'hF); end
      do_write(4'hC, 32'h200, 8'd1, 3'd2, 2'd1);
      do_read(4'hD, 32'h200, 8'd3, 3'd2, 2'd1, 1'b1);
      do_read(4'hE, 32'h200, 8'd2, 3'd1, 2'd1, 1'b1);

      for (int k = 0; k < 3; k++) begin wd.push_back(32'hE0 + k); ws.push_back(4'(1 << k)); end
      do_write(4'hF, 32'h300, 8'd2, 3'd2, 2'd0);
      do_read(4'h2, 32'h300, 8'd2, 3'd2, 2'd0, 1'b1);

      for (int i = 0; i < 60; i++) begin
         logic [31:0] addr;
         logic [7:0] len;
         logic [1:0] burst;
         logic [2:0] size;
         int nb;
         burst = 2'($urandom_range(0, 3));
         len = 8'($urandom_range(0, 15));
         if (burst == 2'd2 && $urandom_range(0, 3) != 0) len = 8'((1 << $urandom_range(1, 4)) - 1);
         size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 4)) : 3'd2;
         addr = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) * 4
                                            : 32'($urandom_range(0, 240)) * 4 + 32'($urandom_range(0, 3));
         rdy_mode = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 1) begin
            nb = int'(len) + 1;
            if ($urandom_range(0, 5) == 0) nb = $urandom_range(1, int'(len) + 3);
            for (int k = 0; k < nb; k++) begin wd.push_back($urandom); ws.push_back(4'($urandom)); end
            do_write(4'($urandom), addr, len, size, burst);
         end else begin
            do_read(4'($urandom), addr, len, size, burst, 1'b1);
         end
      end

      rdy_mode = 0;
      do_read(4'h6, 32'h0, 8'd7, 3'd2, 2'd1, 1'b0);
      repeat (2) @(negedge aclk);
      @(posedge aclk);
      #2;
      aresetn = 1'b0;
      #1;
      check("rvalid_in_reset", {62'd0, s_rvalid, s_rlast}, 64'd0);
      r_q.delete();
      repeat (2) @(negedge aclk);
      check("arready_in_reset", 64'(s_arready), 64'd0);
      aresetn = 1'b1;
      @(negedge aclk);
      check("arready_after_reset", 64'(s_arready), 64'd1);
      do_read(4'h1, 32'h0, 8'd7, 3'd2, 2'd1, 1'b1);

      repeat (3) @(negedge aclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
